button_uart_tx: RTL and testbench

BUTTON_UART_TX -- requirements
Module: button_uart_tx

---
 rtl/button_uart_tx.sv | 159 +++++++++++++++
 tb/tb_button_uart_tx.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/button_uart_tx.sv
// +------------------------------------------------------------------------+
// | button_uart_tx : sends sw_in as one 8N1 UART frame per button press,   |
// |                  with a one-entry pending buffer for early presses.    |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
`default_nettype none

module button_uart_tx #(
   parameter int clk_freq  = 100_000_000,
   parameter int baud_rate = 115_200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_in,
   input  logic [7:0] sw_in,
   output logic       tx,
   output logic       busy,
   output logic       tx_done,
   output logic       overrun
);

   localparam int bit_period = clk_freq / baud_rate;
   localparam int c_TIMER_W  = $clog2(bit_period + 1);
   localparam logic [c_TIMER_W-1:0] c_BIT_LAST = c_TIMER_W'(bit_period - 1);
   // tx_done is registered, so it is scheduled one cycle before the stop bit ends
   localparam logic [c_TIMER_W-1:0] c_BIT_DONE = c_TIMER_W'(bit_period - 2);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t               state_q;
   logic [c_TIMER_W-1:0] timer_q;
   logic [2:0]           bit_idx_q;
   logic [7:0]           shreg_q;
   logic                 pend_valid_q;
   logic [7:0]           pend_data_q;
   logic                 btn_prev_q;
   logic                 tx_q;
   logic                 busy_q;
   logic                 tx_done_q;
   logic                 overrun_q;

   logic w_press;
   logic w_bit_end;
   logic w_stop_end;

   assign w_press    = btn_in & ~btn_prev_q;
   assign w_bit_end  = (timer_q == c_BIT_LAST);
   assign w_stop_end = (state_q == S_STOP) && w_bit_end;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         timer_q      <= '0;
         bit_idx_q    <= '0;
         shreg_q      <= '0;
         pend_valid_q <= 1'b0;
         pend_data_q  <= '0;
         btn_prev_q   <= 1'b1;
         tx_q         <= 1'b1;
         busy_q       <= 1'b0;
         tx_done_q    <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         btn_prev_q <= btn_in;
         tx_done_q  <= 1'b0;
         overrun_q  <= 1'b0;

         if (state_q != S_IDLE) begin
            timer_q <= w_bit_end ? '0 : timer_q + 1'b1;
         end

         // Mid-frame presses fill the pending slot; the stop-bit end handles its own
         if ((state_q != S_IDLE) && w_press && !w_stop_end) begin
            if (pend_valid_q) begin
               overrun_q <= 1'b1;
            end else begin
               pend_data_q  <= sw_in;
               pend_valid_q <= 1'b1;
            end
         end

         case (state_q)
            S_IDLE: begin
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
               timer_q <= '0;
               if (w_press) begin
                  shreg_q <= sw_in;
                  state_q <= S_START;
                  tx_q    <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  state_q   <= S_DATA;
                  bit_idx_q <= '0;
                  tx_q      <= shreg_q[0];
                  shreg_q   <= {1'b0, shreg_q[7:1]};
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  if (bit_idx_q == 3'd7) begin
                     state_q <= S_STOP;
                     tx_q    <= 1'b1;
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                     tx_q      <= shreg_q[0];
                     shreg_q   <= {1'b0, shreg_q[7:1]};
                  end
               end
            end
            S_STOP: begin
               if (timer_q == c_BIT_DONE) begin
                  tx_done_q <= 1'b1;
               end
               if (w_bit_end) begin
                  if (pend_valid_q) begin
                     shreg_q <= pend_data_q;
                     state_q <= S_START;
                     tx_q    <= 1'b0;
                     if (w_press) begin
                        pend_data_q <= sw_in;
                     end else begin
                        pend_valid_q <= 1'b0;
                     end
                  end else if (w_press) begin
                     shreg_q <= sw_in;
                     state_q <= S_START;
                     tx_q    <= 1'b0;
                  end else begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign tx      = tx_q;
   assign busy    = busy_q;
   assign tx_done = tx_done_q;
   assign overrun = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_button_uart_tx.sv
// +------------------------------------------------------------------------+
// | tb_button_uart_tx : directed self-checking bench for button_uart_tx.    |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_button_uart_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_in = 1'b0;
   logic [7:0] sw_in = 8'h00;
   logic       tx;
   logic       busy;
   logic       tx_done;
   logic       overrun;

   int checks   = 0;
   int failures = 0;

   button_uart_tx #(
      .clk_freq  (1000),
      .baud_rate (100)
   ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .btn_in  (btn_in),
      .sw_in   (sw_in),
      .tx      (tx),
      .busy    (busy),
      .tx_done (tx_done),
      .overrun (overrun)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int cyc, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
      end
   endtask

   // Idle line: tx high, nothing busy, no pulses.
   task automatic idle(input int n, input string tag);
      for (int i = 1; i <= n; i++) begin
         tick();
         chk({tag, "_tx"}, i, {7'd0, tx}, 8'h01);
         chk({tag, "_busy"}, i, {7'd0, busy}, 8'h00);
         chk({tag, "_done"}, i, {7'd0, tx_done}, 8'h00);
         chk({tag, "_ovr"}, i, {7'd0, overrun}, 8'h00);
      end
   endtask

   // Enters just before the edge that samples the press; checks frame cycles 1..last.
   // A press at cycle p is driven during cycle p and sampled at the edge ending it.
   task automatic frame(input logic [7:0] d, input int last,
                        input int p1, input logic [7:0] d1,
                        input int p2, input logic [7:0] d2,
                        input int ovr, input bit tog);
      logic [7:0] rx;
      logic       exp_tx;
      rx = 8'h00;
      for (int c = 1; c <= last; c++) begin
         tick();
         if (c <= 10)      exp_tx = 1'b0;
         else if (c <= 90) exp_tx = d[(c - 11) / 10];
         else              exp_tx = 1'b1;
         chk("frm_tx", c, {7'd0, tx}, {7'd0, exp_tx});
         chk("frm_busy", c, {7'd0, busy}, 8'h01);
         chk("frm_done", c, {7'd0, tx_done}, (c == 100) ? 8'h01 : 8'h00);
         chk("frm_ovr", c, {7'd0, overrun}, (c == ovr) ? 8'h01 : 8'h00);
         if ((c >= 15) && (c <= 85) && ((c % 10) == 5)) rx[(c - 15) / 10] = tx;
         btn_in = (c == p1) || (c == p2);
         if (c == p1) sw_in = d1;
         if (c == p2) sw_in = d2;
         if (tog) sw_in = ~sw_in;
      end
      if (last == 100) chk("frm_byte", last, rx, d);
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      btn_in = 1'b0;
      tick();
      tick();
      chk("rst_tx", 0, {7'd0, tx}, 8'h01);
      chk("rst_busy", 0, {7'd0, busy}, 8'h00);
      chk("rst_done", 0, {7'd0, tx_done}, 8'h00);
      chk("rst_ovr", 0, {7'd0, overrun}, 8'h00);
      rst = 1'b0;
      idle(5, "init");

      // Single press, 0xA5
      sw_in = 8'hA5;
      btn_in = 1'b1;
      frame(8'hA5, 100, -1, 8'h00, -1, 8'h00, 0, 1'b0);
      idle(30, "a5_after");

      // Back-to-back: 02 pends, 03 overruns and is dropped
      sw_in = 8'h01;
      btn_in = 1'b1;
      frame(8'h01, 100, 30, 8'h02, 50, 8'h03, 51, 1'b0);
      frame(8'h02, 100, -1, 8'h00, -1, 8'h00, 0, 1'b0);
      idle(150, "b2b_after");

      // Press on the last stop cycle with nothing pending
      sw_in = 8'h5A;
      btn_in = 1'b1;
      frame(8'h5A, 100, 100, 8'hC3, -1, 8'h00, 0, 1'b0);
      frame(8'hC3, 100, -1, 8'h00, -1, 8'h00, 0, 1'b0);
      idle(30, "laststop_after");

      // Reset at frame cycle 45 with 0x7E pending
      sw_in = 8'h81;
      btn_in = 1'b1;
      frame(8'h81, 45, 20, 8'h7E, -1, 8'h00, 0, 1'b0);
      rst = 1'b1;
      tick();
      chk("midrst_tx", 46, {7'd0, tx}, 8'h01);
      chk("midrst_busy", 46, {7'd0, busy}, 8'h00);
      chk("midrst_done", 46, {7'd0, tx_done}, 8'h00);
      rst = 1'b0;
      idle(200, "midrst_after");

      // Button held through reset release
      btn_in = 1'b1;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      idle(500, "held");
      btn_in = 1'b0;
      idle(2, "held_rel");
      sw_in = 8'h96;
      btn_in = 1'b1;
      frame(8'h96, 100, -1, 8'h00, -1, 8'h00, 0, 1'b0);
      idle(200, "held_after");

      // sw_in toggling every cycle during a 0x3C frame
      sw_in = 8'h3C;
      btn_in = 1'b1;
      frame(8'h3C, 100, -1, 8'h00, -1, 8'h00, 0, 1'b1);
      idle(20, "tog_after");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
